// File: rtl/mm_row_sched.sv
// Row scheduler for a BRAM-backed matrix-vector unit: streams N element reads per row,
// then writes one accumulated result per row, with abort and command validation.
module mm_row_sched #(
   parameter int N          = 4,
   parameter int DW         = 2,
   parameter int BRAM_DEPTH = 32,
   parameter int MAX_ROWS   = 8,
   localparam int AW        = $clog2(BRAM_DEPTH),
   localparam int RW        = $clog2(MAX_ROWS) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [RW-1:0] cmd_rows,
   input  logic [AW-1:0] cmd_rd_base,
   input  logic [AW-1:0] cmd_wr_base,
   input  logic          abort,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   output logic          acc_en,
   output logic          acc_init,
   output logic          mem_wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [RW-1:0] row_idx,
   output logic          busy,
   output logic          done,
   output logic          err
);

   // DW has no role in scheduling; it only rides along so the element counter width sees it.
   localparam int EW = $clog2(N) + 0 * DW;
   localparam logic [RW-1:0] MAX_R     = RW'(MAX_ROWS);
   localparam logic [EW-1:0] ELEM_LAST = EW'(N - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_WRITE,
      S_DONE
   } state_t;

   state_t        state_q;
   logic [RW-1:0] rows_q;
   logic [RW-1:0] row_idx_q;
   logic [EW-1:0] elem_q;
   logic [AW-1:0] wr_base_q;
   logic [AW-1:0] rd_addr_q;
   logic [AW-1:0] wr_addr_q;
   logic          acc_en_q;
   logic          acc_init_q;
   logic          done_q;
   logic          err_q;

   logic [AW-1:0] wr_addr_d;
   logic          last_row;

   assign wr_addr_d = wr_base_q + AW'(row_idx_q);
   assign last_row  = (row_idx_q == rows_q - RW'(1));

   // Rows are contiguous, so the read address simply advances by one per element
   // (holding across WAIT/WRITE) instead of recomputing base + row*N + elem.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         rows_q     <= '0;
         row_idx_q  <= '0;
         elem_q     <= '0;
         wr_base_q  <= '0;
         rd_addr_q  <= '0;
         wr_addr_q  <= '0;
         acc_en_q   <= 1'b0;
         acc_init_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         acc_en_q   <= 1'b0;
         acc_init_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  if (cmd_rows == '0) begin
                     done_q <= 1'b1;
                  end else if (cmd_rows > MAX_R) begin
                     err_q <= 1'b1;
                  end else begin
                     rows_q    <= cmd_rows;
                     wr_base_q <= cmd_wr_base;
                     rd_addr_q <= cmd_rd_base;
                     row_idx_q <= '0;
                     elem_q    <= '0;
                     state_q   <= S_READ;
                  end
               end
            end
            S_READ: begin
               if (abort) begin
                  elem_q  <= '0;
                  state_q <= S_IDLE;
               end else begin
                  acc_en_q   <= 1'b1;
                  acc_init_q <= (elem_q == '0);
                  if (elem_q == ELEM_LAST) begin
                     elem_q  <= '0;
                     state_q <= S_WAIT;
                  end else begin
                     elem_q    <= elem_q + EW'(1);
                     rd_addr_q <= rd_addr_q + AW'(1);
                  end
               end
            end
            S_WAIT: begin
               if (abort) begin
                  state_q <= S_IDLE;
               end else begin
                  wr_addr_q <= wr_addr_d;
                  state_q   <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (abort) begin
                  state_q <= S_IDLE;
               end else if (last_row) begin
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  row_idx_q <= row_idx_q + RW'(1);
                  rd_addr_q <= rd_addr_q + AW'(1);
                  state_q   <= S_READ;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign rd_en     = (state_q == S_READ);
   assign mem_wr_en = (state_q == S_WRITE);
   assign rd_addr   = rd_addr_q;
   assign wr_addr   = wr_addr_q;
   assign row_idx   = row_idx_q;
   assign acc_en    = acc_en_q;
   assign acc_init  = acc_init_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: doc/mm_row_sched.md
MM_ROW_SCHED -- requirements
Module: mm_row_sched

Interface
REQ-001 Parameter N, default 4, elements per row (dot-product length), N>=2.
REQ-002 Parameter DW, default 2, element width (carried for datapath consistency; unused internally).
REQ-003 Parameter BRAM_DEPTH, default 32, words per BRAM; AW = $clog2(BRAM_DEPTH).
REQ-004 Parameter MAX_ROWS, default 8, largest legal row count; RW = $clog2(MAX_ROWS)+1.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 cmd_valid  in  1  command offered.
REQ-008 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-009 cmd_rows  in  RW  rows to process.
REQ-010 cmd_rd_base  in  AW  BRAM address of row 0, element 0.
REQ-011 cmd_wr_base  in  AW  BRAM address for the row-0 result.
REQ-012 abort  in  1  cancel the active job.
REQ-013 rd_en  out  1  BRAM read strobe.
REQ-014 rd_addr  out  AW  BRAM read address.
REQ-015 acc_en  out  1  read data valid; the accumulator adds this cycle.
REQ-016 acc_init  out  1  first element of a row; the accumulator loads instead of adding.
REQ-017 mem_wr_en  out  1  write the accumulator result.
REQ-018 wr_addr  out  AW  BRAM write address.
REQ-019 row_idx  out  RW  row currently being processed.
REQ-020 busy  out  1  high in every state except IDLE.
REQ-021 done  out  1  one-cycle pulse, job complete.
REQ-022 err  out  1  one-cycle pulse, command rejected.

Function
REQ-023 FSM states IDLE, READ, WAIT, WRITE, DONE; all outputs SHALL decode from registers, with no combinational input-to-output path.
REQ-024 cmd_ready = (state==IDLE).
REQ-025 IDLE, on accept with 1<=cmd_rows<=MAX_ROWS: latch rows, rd_base and wr_base; row_idx=0; elem=0; next state READ.
REQ-026 IDLE, on accept with cmd_rows==0: done=1 the next cycle; stay IDLE; no rd_en or mem_wr_en.
REQ-027 IDLE, on accept with cmd_rows>MAX_ROWS: err=1 the next cycle; stay IDLE; no done and no rd_en.
REQ-028 READ: rd_en=1; rd_addr = rd_base + row_idx*N + elem, modulo BRAM_DEPTH (truncated to AW bits, wraps silently); elem increments each cycle.
REQ-029 READ with elem==N-1: next state WAIT; elem clears to 0.
REQ-030 acc_en SHALL equal rd_en delayed 1 cycle (BRAM read latency 1).
REQ-031 acc_init SHALL equal (rd_en && elem==0) delayed 1 cycle.
REQ-032 WAIT: lasts 1 cycle; carries the last acc_en of the row; next state WRITE.
REQ-033 WRITE: mem_wr_en=1; wr_addr = wr_base + row_idx, modulo BRAM_DEPTH.
REQ-034 WRITE with row_idx==rows-1: next state DONE; otherwise row_idx increments and next state READ.
REQ-035 DONE: done=1 for 1 cycle; next state IDLE.
REQ-036 Timing: each row takes N+2 cycles; a job takes rows*(N+2)+1 cycles from the first READ cycle to the DONE cycle inclusive.
REQ-037 abort in READ, WAIT or WRITE: next state IDLE; rd_en, acc_en, acc_init and mem_wr_en are 0 from the next cycle; the delay pipeline clears; no done pulse.
REQ-038 abort in IDLE or DONE is ignored; a command accepted in the same cycle proceeds normally, and DONE still pulses.
REQ-039 wr_addr and rd_addr hold their last values when idle.

Reset
REQ-040 On rst: state=IDLE and cmd_ready=1.
REQ-041 On rst: busy, done, err, rd_en, acc_en, acc_init and mem_wr_en = 0.
REQ-042 On rst: rd_addr, wr_addr, row_idx and elem = 0.
REQ-043 rst during an active job SHALL discard it immediately, with no done and no write on the following cycle.

Verification (N=4, BRAM_DEPTH=32, MAX_ROWS=8)
REQ-044 rows=2, rd_base=0, wr_base=16, accepted at cycle 0:
- rd_addr 0-3 in cycles 1-4 and 4-7 in cycles 7-10;
- acc_init in cycles 2 and 8;
- mem_wr_en at addr 16 in cycle 6 and addr 17 in cycle 12;
- done in cycle 13.
REQ-045 rows=1, rd_base=30: rd_addr sequence 30,31,0,1; write to wr_base.
REQ-046 rows=0: done in cycle 1, busy stays 0, no rd_en.
REQ-047 rows=9: err in cycle 1, no done, no rd_en, cmd_ready stays 1.
REQ-048 abort in cycle 8 of the REQ-044 job: rd_en=0 from cycle 9, no write to 17, no done, cmd_ready=1 in cycle 9.
REQ-049 cmd_valid held high with a second rows=1 command: accepted in the DONE cycle's successor (IDLE), first READ one cycle later.
